// File: rtl/types.sv
`default_nettype none
// ============================================================================
//  Package    : types
//  Description: Shared USB line-state and receive-state definitions used by
//               the SIE receive path, usb_controller debug and benches.
//  Revision   : 1.1 - receive-state enum and SIE receive helpers added
// ============================================================================
package types;

   // Synchronized D+/D- pair, {dp, dm}. Low-speed J is D- high.
   typedef enum logic [1:0] {
      SE0 = 2'b00,
      J   = 2'b01,
      K   = 2'b10,
      SE1 = 2'b11
   } d_port_t;

   // Receive framing state of usb_sie_rx.
   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_SYNC  = 3'd1,
      RX_DATA  = 3'd2,
      RX_EOP   = 3'd3,
      RX_ERROR = 3'd4
   } rx_state_t;

   // Consecutive ones after which the next bit must be a stuffed zero.
   localparam logic [2:0] STUFF_RUN   = 3'd6;
   // Last count of consecutive J samples that ends error recovery (8 samples).
   localparam logic [2:0] IDLE_J_LAST = 3'd7;

   // NRZI: no level change means a one, a change means a zero.
   function automatic logic nrzi_bit(input d_port_t lvl, input d_port_t prev_lvl);
      return (lvl == prev_lvl);
   endfunction

endpackage
`default_nettype wire

// File: rtl/usb_rx_dpll.sv
`default_nettype none
// ============================================================================
//  Module     : usb_rx_dpll
//  Description: Bit-timing recovery. A phase counter is re-centred on every
//               line transition and emits a one-cycle sample strobe in the
//               middle of each bit cell.
//  Revision   : 1.0 - initial release
// ============================================================================
module usb_rx_dpll
   import types::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic    clk,
   input  logic    reset,
   input  d_port_t line_state,
   output logic    sample_stb
);

   localparam int            PW           = $clog2(CLKS_PER_BIT);
   localparam logic [PW-1:0] PHASE_MAX    = PW'(CLKS_PER_BIT - 1);
   localparam logic [PW-1:0] PHASE_SAMPLE = PW'(CLKS_PER_BIT / 2);

   logic [PW-1:0] phase_q, phase_d;
   d_port_t       line_prev_q, line_prev_d;
   logic          line_change;

   // Restart the phase on any transition, otherwise free-run and wrap.
   always_comb begin
      line_prev_d = line_state;
      line_change = (line_state != line_prev_q);
      if (line_change) begin
         phase_d = '0;
      end else if (phase_q == PHASE_MAX) begin
         phase_d = '0;
      end else begin
         phase_d = phase_q + 1'b1;
      end
      // A transition exactly at mid-cell means the estimate is stale; skip it.
      sample_stb = !line_change && (phase_q == PHASE_SAMPLE);
   end

   // Phase and previous-line registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_q     <= '0;
         line_prev_q <= J;
      end else begin
         phase_q     <= phase_d;
         line_prev_q <= line_prev_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/usb_sie_rx.sv
`default_nettype none
// ============================================================================
//  Module     : usb_sie_rx
//  Description: Low-speed USB receive front end. NRZI decode, bit unstuffing,
//               SYNC and EOP detection, byte assembly towards usb_controller.
//  Revision   : 1.0 - initial release
// ============================================================================
module usb_sie_rx
   import types::*;
#(
   parameter int CLKS_PER_BIT   = 16,
   parameter int SYNC_MIN_ZEROS = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  d_port_t    line_state,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_active,
   output logic       rx_error
);

   localparam logic [2:0] SYNC_MIN = 3'(SYNC_MIN_ZEROS);

   rx_state_t  state_q, state_d;
   d_port_t    prev_lvl_q, prev_lvl_d;
   logic [2:0] ones_q, ones_d;
   logic [2:0] zeros_q, zeros_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       se0_seen_q, se0_seen_d;
   logic [2:0] j_cnt_q, j_cnt_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       rx_active_q, rx_active_d;
   logic       rx_error_q, rx_error_d;

   logic       sample_stb;
   logic       line_is_jk;
   logic       dec_bit;
   logic       to_idle;
   logic       to_error;

   usb_rx_dpll #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_dpll (
      .clk        (clk),
      .reset      (reset),
      .line_state (line_state),
      .sample_stb (sample_stb)
   );

   // Per-sample decode and framing decisions; outputs are registered below.
   always_comb begin
      state_d     = state_q;
      prev_lvl_d  = prev_lvl_q;
      ones_d      = ones_q;
      zeros_d     = zeros_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      se0_seen_d  = se0_seen_q;
      j_cnt_d     = j_cnt_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      rx_active_d = rx_active_q;
      rx_error_d  = rx_error_q;
      to_idle     = 1'b0;
      to_error    = 1'b0;
      line_is_jk  = (line_state == J) || (line_state == K);
      dec_bit     = nrzi_bit(line_state, prev_lvl_q);

      if (sample_stb) begin
         // SE0/SE1 carry no NRZI information, so the reference level holds.
         if (line_is_jk) begin
            prev_lvl_d = line_state;
         end

         case (state_q)
            RX_IDLE: begin
               ones_d = 3'd0;
               if (line_state == K) begin
                  state_d = RX_SYNC;
                  zeros_d = 3'd0;
               end
            end

            RX_SYNC: begin
               if (!line_is_jk) begin
                  to_idle = 1'b1;
               end else if (!dec_bit) begin
                  zeros_d = (zeros_q == 3'd7) ? 3'd7 : zeros_q + 3'd1;
                  ones_d  = 3'd0;
               end else if (zeros_q >= SYNC_MIN) begin
                  // The closing SYNC one starts the stuffing run.
                  state_d     = RX_DATA;
                  rx_active_d = 1'b1;
                  ones_d      = 3'd1;
                  bit_cnt_d   = 3'd0;
               end else begin
                  to_idle = 1'b1;
               end
            end

            RX_DATA: begin
               if (line_state == SE0) begin
                  state_d    = RX_EOP;
                  rx_error_d = (bit_cnt_q != 3'd0);
               end else if (line_state == SE1) begin
                  to_error = 1'b1;
               end else if (ones_q == STUFF_RUN) begin
                  // A stuffed zero is dropped; a seventh one is illegal.
                  if (dec_bit) begin
                     to_error = 1'b1;
                  end else begin
                     ones_d = 3'd0;
                  end
               end else begin
                  ones_d    = dec_bit ? ones_q + 3'd1 : 3'd0;
                  shift_d   = {dec_bit, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     rx_data_d  = {dec_bit, shift_q[7:1]};
                     rx_valid_d = 1'b1;
                  end
               end
            end

            RX_EOP: begin
               if (line_state == J) begin
                  to_idle = 1'b1;
               end else if (line_state != SE0) begin
                  to_error = 1'b1;
               end
            end

            RX_ERROR: begin
               case (line_state)
                  SE0: begin
                     se0_seen_d = 1'b1;
                     j_cnt_d    = 3'd0;
                  end
                  J: begin
                     if (se0_seen_q || (j_cnt_q == IDLE_J_LAST)) begin
                        to_idle = 1'b1;
                     end else begin
                        j_cnt_d = j_cnt_q + 3'd1;
                     end
                  end
                  default: begin
                     se0_seen_d = 1'b0;
                     j_cnt_d    = 3'd0;
                  end
               endcase
            end

            default: begin
               to_idle = 1'b1;
            end
         endcase
      end

      if (to_error) begin
         state_d    = RX_ERROR;
         rx_error_d = 1'b1;
         se0_seen_d = 1'b0;
         j_cnt_d    = 3'd0;
      end

      if (to_idle) begin
         state_d     = RX_IDLE;
         prev_lvl_d  = J;
         ones_d      = 3'd0;
         zeros_d     = 3'd0;
         bit_cnt_d   = 3'd0;
         se0_seen_d  = 1'b0;
         j_cnt_d     = 3'd0;
         rx_active_d = 1'b0;
         rx_error_d  = 1'b0;
      end
   end

   // Framing state, datapath and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= RX_IDLE;
         prev_lvl_q  <= J;
         ones_q      <= 3'd0;
         zeros_q     <= 3'd0;
         shift_q     <= 8'h00;
         bit_cnt_q   <= 3'd0;
         se0_seen_q  <= 1'b0;
         j_cnt_q     <= 3'd0;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         rx_active_q <= 1'b0;
         rx_error_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_lvl_q  <= prev_lvl_d;
         ones_q      <= ones_d;
         zeros_q     <= zeros_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         se0_seen_q  <= se0_seen_d;
         j_cnt_q     <= j_cnt_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         rx_active_q <= rx_active_d;
         rx_error_q  <= rx_error_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign rx_active = rx_active_q;
   assign rx_error  = rx_error_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_sie_rx.sv
`default_nettype none
// ============================================================================
//  Module     : tb_usb_sie_rx
//  Description: Bench for usb_sie_rx. Directed packets are NRZI-encoded and
//               stuffed by the bench; expected bytes go into a queue that a
//               free-running monitor pops on every rx_valid.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_usb_sie_rx;
   import types::*;

   logic       clk = 1'b0;
   logic       reset;
   d_port_t    line_state;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_active;
   logic       rx_error;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   int         nvalid = 0;
   bit         saw_err = 1'b0;
   bit         saw_active = 1'b0;

   d_port_t    lvl = J;
   int         ones = 0;
   bit         jitter = 1'b0;
   bit         tgl = 1'b0;

   usb_sie_rx #(
      .CLKS_PER_BIT   (16),
      .SYNC_MIN_ZEROS (5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .line_state (line_state),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_active  (rx_active),
      .rx_error   (rx_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every delivered byte.
   initial begin
      forever begin
         @(negedge clk);
         if (rx_error === 1'b1) saw_err = 1'b1;
         if (rx_active === 1'b1) saw_active = 1'b1;
         if (rx_valid === 1'b1) begin
            nvalid++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid: got rx_data=%02h, no byte expected", rx_data);
            end else begin
               mon_exp = exp_q.pop_front();
               if (rx_data !== mon_exp) begin
                  errors++;
                  $display("FAIL rx_data: got %02h, expected %02h", rx_data, mon_exp);
               end
            end
            checks++;
            if (!(rx_active === 1'b1 && rx_error === 1'b0)) begin
               errors++;
               $display("FAIL valid_qual: got active=%b error=%b, expected active=1 error=0",
                        rx_active, rx_error);
            end
         end
      end
   end

   task automatic drive(input d_port_t v, input int n);
      line_state = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_raw_bit(input bit b);
      int len;
      if (!b) lvl = (lvl == J) ? K : J;
      len = jitter ? (tgl ? 15 : 17) : 16;
      tgl = ~tgl;
      drive(lvl, len);
   endtask

   task automatic send_bit(input bit b);
      send_raw_bit(b);
      ones = b ? ones + 1 : 0;
      if (ones == 6) begin
         send_raw_bit(1'b0);
         ones = 0;
      end
   endtask

   task automatic send_sync();
      lvl = J;
      for (int i = 0; i < 7; i++) send_raw_bit(1'b0);
      send_raw_bit(1'b1);
      ones = 1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit push);
      if (push) exp_q.push_back(b);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
   endtask

   task automatic send_eop();
      drive(SE0, 32);
      lvl = J;
      drive(J, 16);
      drive(J, 40);
   endtask

   task automatic start_packet();
      saw_err    = 1'b0;
      saw_active = 1'b0;
      nvalid     = 0;
   endtask

   task automatic check_closed(input string name);
      check({name, "_active_end"}, {31'd0, rx_active}, 32'd0);
      check({name, "_error_end"}, {31'd0, rx_error}, 32'd0);
      check({name, "_queue_empty"}, exp_q.size(), 32'd0);
   endtask

   // Watchdog: the stimulus is time-bounded, this only guards against a hang.
   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      reset      = 1'b0;
      line_state = J;
      @(negedge clk);

      // Reset held with random line activity.
      for (int i = 0; i < 20; i++) begin
         line_state = d_port_t'($urandom_range(0, 3));
         @(negedge clk);
      end
      check("reset_rx_data", {24'd0, rx_data}, 32'h00);
      check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("reset_rx_active", {31'd0, rx_active}, 32'd0);
      check("reset_rx_error", {31'd0, rx_error}, 32'd0);
      reset = 1'b1;
      start_packet();
      drive(J, 100);
      check("idle_no_active", {31'd0, saw_active}, 32'd0);
      check("idle_no_valid", nvalid, 32'd0);

      // Token: PID 69, bytes 05 80.
      start_packet();
      send_sync();
      check("token_active_after_sync", {31'd0, rx_active}, 32'd1);
      send_byte(8'h69, 1'b1);
      send_byte(8'h05, 1'b1);
      send_byte(8'h80, 1'b1);
      send_eop();
      check("token_nvalid", nvalid, 32'd3);
      check("token_no_error", {31'd0, saw_err}, 32'd0);
      check_closed("token");

      // Stuffing: FF FF with inserted zeros.
      start_packet();
      send_sync();
      send_byte(8'hFF, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_eop();
      check("stuff_nvalid", nvalid, 32'd2);
      check("stuff_no_error", {31'd0, saw_err}, 32'd0);
      check_closed("stuff");

      // Stuff error: 00 then seven unstuffed ones.
      start_packet();
      send_sync();
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 6; i++) send_raw_bit(1'b1);
      check("stufferr_six_ones_ok", {31'd0, rx_error}, 32'd0);
      send_raw_bit(1'b1);
      check("stufferr_error_set", {31'd0, rx_error}, 32'd1);
      check("stufferr_active_held", {31'd0, rx_active}, 32'd1);
      send_eop();
      check("stufferr_nvalid", nvalid, 32'd1);
      check_closed("stufferr");

      // Framing: C3 plus four stray bits, then EOP.
      start_packet();
      send_sync();
      send_byte(8'hC3, 1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      drive(SE0, 32);
      check("frame_error_in_eop", {31'd0, rx_error}, 32'd1);
      lvl = J;
      drive(J, 16);
      drive(J, 40);
      check("frame_nvalid", nvalid, 32'd1);
      check_closed("frame");

      // Jitter: A5 with alternating 15/17-clock bits.
      start_packet();
      send_sync();
      jitter = 1'b1;
      send_byte(8'hA5, 1'b1);
      jitter = 1'b0;
      send_eop();
      check("jitter_nvalid", nvalid, 32'd1);
      check("jitter_no_error", {31'd0, saw_err}, 32'd0);
      check_closed("jitter");

      // Asynchronous reset four bits into a packet.
      start_packet();
      send_sync();
      for (int i = 0; i < 4; i++) send_bit(i[0]);
      check("midreset_active_before", {31'd0, rx_active}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("midreset_rx_active", {31'd0, rx_active}, 32'd0);
      check("midreset_rx_error", {31'd0, rx_error}, 32'd0);
      check("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("midreset_rx_data", {24'd0, rx_data}, 32'h00);
      @(negedge clk);
      drive(K, 5);
      reset = 1'b1;
      start_packet();
      drive(J, 200);
      check("midreset_no_valid", nvalid, 32'd0);
      check("midreset_no_active", {31'd0, saw_active}, 32'd0);
      check_closed("midreset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/usb_sie_rx.md
# usb_sie_rx

Low-speed USB receive front end of the serial interface engine. It recovers bit timing from the synchronized `line_state` and performs NRZI decoding, bit unstuffing, SYNC detection and EOP detection. It delivers packet bytes to `usb_controller` on the `rx_data`/`rx_valid`/`rx_active`/`rx_error` interface. It sits between the D+/D- input synchronizer and `usb_controller`, on the 24 MHz system clock.

## Interface
- `CLKS_PER_BIT`, default 16: system clocks per bit. 24 MHz / 1.5 Mbps gives 16. Must be ≥ 8.
- `SYNC_MIN_ZEROS`, default 5: minimum number of decoded SYNC zeros before the terminating 1.
- `clk`  in  1  system clock, 24 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `line_state`  in  `d_port_t`  synchronized D+/D- (values SE0, J, K, SE1).
- `rx_data`  out  8  received byte, LSB received first.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is valid in that cycle.
- `rx_active`  out  1  high from the end of SYNC to the end of EOP or error recovery.
- `rx_error`  out  1  level; stuff, SE1 or framing error in the current packet.

## Operation
- Reset values: `rx_data` = 8'h00, `rx_valid`, `rx_active` and `rx_error` = 0. State is IDLE, phase = 0, previous level = J, ones count = 0.
- **DPLL:** phase counter 0..CLKS_PER_BIT-1. It is forced to 0 on any `line_state` change and otherwise wraps. The line is sampled when phase = CLKS_PER_BIT/2.
- **NRZI:** decoded bit = 1 if the sampled level equals the previous sampled J/K level, else 0. An SE0 sample is not decoded.
- **Unstuff:** the ones counter increments on each decoded 1 and clears on each 0. The bit following six consecutive 1s is discarded if it is 0. If that bit is 1, it is a stuff error.
- **States:**
  - IDLE: on the first K → SYNC, with zero count = 0.
  - SYNC: a decoded 0 increments the zero count, saturating at 7. A decoded 1 with count ≥ SYNC_MIN_ZEROS → DATA and `rx_active` ← 1. A decoded 1 with a lower count, or any SE0/SE1 sample → IDLE, with no output activity.
  - DATA: each unstuffed bit shifts into bit 7 of the shift register, with a 3-bit counter. On the 8th bit, `rx_data` ← shift value and `rx_valid` pulses. An SE0 sample → EOP. A stuff error or SE1 sample → ERROR.
  - EOP: if the bit counter ≠ 0 (partial byte), `rx_error` ← 1. The next J sample → IDLE and `rx_active` ← 0, `rx_error` ← 0. A K or SE1 sample → ERROR.
  - ERROR: `rx_error` = 1 and `rx_active` stays 1. It waits for SE0 followed by a J sample, or 8 consecutive J samples (idle). Either → IDLE, dropping both outputs.
- A byte completing in the same sample as a stuff error is not delivered.
- The previous-level register loads only on J/K samples and reloads to J on entry to IDLE.

## Timing
- Line edge to sample point: CLKS_PER_BIT/2 clocks.
- `rx_valid`, `rx_data`, `rx_active` and `rx_error` are registered. They change 1 clock after the deciding sample.
- `rx_valid` is never high while `rx_active` = 0 or `rx_error` = 1. Consecutive `rx_valid` pulses are at least 8 × CLKS_PER_BIT clocks apart.
- `rx_active` falls 1 clock after the first J sample following EOP SE0, which is about 2.5 bit times after SE0 starts.
- There is no ready/backpressure; the consumer must accept every `rx_valid`.
- Asserting `reset` mid-packet returns all outputs to their reset values immediately (asynchronous). Reception restarts only at the next SYNC.
- Jitter tolerance: every edge re-centres the phase. A run of 7 bits without a transition is the maximum, which stuffing guarantees.

## Structure
- `d_port_t` comes from package `types`, which is already shared.
- Add a receive-state enum to `types` so `usb_controller` debug and benches share it.
- Natural sub-module: `usb_rx_dpll` (phase counter plus sample strobe, parameterized by CLKS_PER_BIT). The NRZI, unstuff and framing logic live in `usb_sie_rx`.

## Test plan
- **Reset:** `reset` low during random `line_state` → all outputs 0. Release, then J idle for 100 clocks → no activity.
- **Token:** SYNC, then PID 8'h69, then bytes 8'h05 and 8'h80, then 2-bit SE0, then J → `rx_active` rises 1 clk after the last SYNC bit sample. `rx_valid` pulses three times with 8'h69, 8'h05, 8'h80. `rx_active` falls, and `rx_error` = 0 throughout.
- **Stuffing:** bytes 8'hFF, 8'hFF with the stuffed zero inserted after every six 1s → two `rx_valid` with 8'hFF and no error.
- **Stuff error:** seven 1s without a stuff bit → `rx_error` = 1 after the 7th bit, no further `rx_valid`. Both outputs clear after the following SE0+J.
- **Framing:** SYNC + 12 data bits (8'hC3 + 4 bits) + EOP → one `rx_valid` with 8'hC3. `rx_error` = 1 during EOP, then both outputs are 0.
- **Jitter/reset:** bit lengths alternating 15/17 clocks carrying 8'hA5 → correct byte. Assert `reset` after 4 data bits of the next packet → immediate zeros and no spurious `rx_valid`.
